// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data and instruction caches: trace command codes,
// address field widths and tag/index extraction helpers.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFF_BITS = 6;

    localparam logic [3:0] CMD_READ   = 4'h0;
    localparam logic [3:0] CMD_WRITE  = 4'h1;
    localparam logic [3:0] CMD_IFETCH = 4'h2;
    localparam logic [3:0] CMD_INVAL  = 4'h3;
    localparam logic [3:0] CMD_CLEAR  = 4'h8;
    localparam logic [3:0] CMD_PRINT  = 4'h9;

    // Width of a field selecting one of n items; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                     input int idx_bits);
        return (a >> OFF_BITS) & ((ADDR_W'(1) << idx_bits) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                   input int idx_bits);
        return a >> (OFF_BITS + idx_bits);
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_BITS], OFF_BITS'(0)};
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Trace-side and next-level bus of the data cache: command/address in, fill line in,
// miss address and hit/miss pulses out.
interface data_cache_if
    import cache_pkg::*;
#(
    parameter int LINE_BITS = 512
);
    logic [3:0]           n;
    logic [ADDR_W-1:0]    add_in;
    logic [LINE_BITS-1:0] d_in;
    logic [ADDR_W-1:0]    add_out;
    logic                 hit;
    logic                 miss;

    modport master (output n, add_in, d_in, input add_out, hit, miss);
    modport slave  (input n, add_in, d_in, output add_out, hit, miss);
endinterface

// File: rtl/lru_way_select.sv
// LRU logic for one set: picks the victim way and returns the ranks after touching
// either the hit way or, on a miss, the victim.
module lru_way_select
    import cache_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int RANK_W = sel_w(WAYS),
    localparam int WAY_W  = sel_w(WAYS)
) (
    input  logic [WAYS*RANK_W-1:0] ranks_i,
    input  logic [WAYS-1:0]        valid_i,
    input  logic                   hit_i,
    input  logic [WAY_W-1:0]       hit_way_i,
    output logic [WAY_W-1:0]       victim_o,
    output logic [WAYS*RANK_W-1:0] ranks_o
);

    logic [WAY_W-1:0]  touched;
    logic [RANK_W-1:0] touched_rank;

    // Lowest invalid way first; only a full set falls back to the LRU-ranked way.
    always_comb begin
        logic found;
        victim_o = '0;
        found    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !valid_i[i]) begin
                victim_o = WAY_W'(i);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < WAYS; i++) begin
                if (ranks_i[i*RANK_W +: RANK_W] == RANK_W'(WAYS - 1)) begin
                    victim_o = WAY_W'(i);
                end
            end
        end
    end

    assign touched      = hit_i ? hit_way_i : victim_o;
    assign touched_rank = ranks_i[touched*RANK_W +: RANK_W];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_rank
            logic [RANK_W-1:0] cur;
            assign cur = ranks_i[gi*RANK_W +: RANK_W];
            assign ranks_o[gi*RANK_W +: RANK_W] =
                (touched == WAY_W'(gi)) ? '0 :
                (cur < touched_rank)    ? cur + 1'b1 : cur;
        end
    endgenerate

endmodule

// File: rtl/data_cache.sv
// L1 data cache: set-associative tag/valid/LRU directory updated on the command edge,
// line data filled from the next level one edge after each miss.
module data_cache
    import cache_pkg::*;
#(
    parameter int SETS      = 256,
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    data_cache_if.slave  bus
);

    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - OFF_BITS - IDX_W;
    localparam int WAY_W    = sel_w(WAYS);
    localparam int RANK_W   = sel_w(WAYS);
    localparam int SET_RANK = WAYS * RANK_W;

    function automatic logic [SET_RANK-1:0] lru_init();
        logic [SET_RANK-1:0] r;
        for (int i = 0; i < WAYS; i++) begin
            r[i*RANK_W +: RANK_W] = RANK_W'(i);
        end
        return r;
    endfunction

    localparam logic [SET_RANK-1:0] LRU_INIT = lru_init();

    // Directory: valid bits and ranks are flat vectors so reset/clear are single assignments.
    logic [TAG_W-1:0]          tag_q [SETS][WAYS];
    logic [SETS*WAYS-1:0]      valid_q;
    logic [SETS*SET_RANK-1:0]  lru_q;
    logic [LINE_BITS-1:0]      line_mem [SETS*WAYS];
    logic [LINE_BITS-1:0]      line_rd_q;

    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [ADDR_W-1:0]    add_out_q, add_out_d;
    logic                 fill_pend_q, fill_pend_d;
    logic [IDX_W-1:0]     fill_set_q;
    logic [WAY_W-1:0]     fill_way_q;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WAYS-1:0]      set_valid;
    logic [SET_RANK-1:0]  set_ranks;
    logic [SET_RANK-1:0]  ranks_upd;
    logic [WAYS-1:0]      match;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim;
    logic                 hit_any;
    logic                 is_access;
    logic                 unused_line_rd;

    assign idx       = IDX_W'(addr_index(bus.add_in, IDX_W));
    assign tag       = TAG_W'(addr_tag(bus.add_in, IDX_W));
    assign set_valid = valid_q[idx*WAYS +: WAYS];
    assign set_ranks = lru_q[idx*SET_RANK +: SET_RANK];
    assign is_access = (bus.n == CMD_READ) || (bus.n == CMD_WRITE);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign match[gi] = set_valid[gi] && (tag_q[idx][gi] == tag);
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) hit_way = WAY_W'(i);
        end
    end

    assign hit_any = |match;

    lru_way_select #(.WAYS(WAYS)) u_lru (
        .ranks_i   (set_ranks),
        .valid_i   (set_valid),
        .hit_i     (hit_any),
        .hit_way_i (hit_way),
        .victim_o  (victim),
        .ranks_o   (ranks_upd)
    );

    always_comb begin
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        add_out_d   = add_out_q;
        fill_pend_d = 1'b0;
        if (is_access) begin
            if (hit_any) begin
                hit_d = 1'b1;
            end else begin
                miss_d      = 1'b1;
                add_out_d   = line_addr(bus.add_in);
                fill_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            add_out_q   <= '0;
            fill_pend_q <= 1'b0;
            fill_set_q  <= '0;
            fill_way_q  <= '0;
            valid_q     <= '0;
            lru_q       <= {SETS{LRU_INIT}};
        end else begin
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            add_out_q   <= add_out_d;
            fill_pend_q <= fill_pend_d;
            if (is_access) begin
                lru_q[idx*SET_RANK +: SET_RANK] <= ranks_upd;
                if (!hit_any) begin
                    valid_q[idx*WAYS + int'(victim)] <= 1'b1;
                    fill_set_q <= idx;
                    fill_way_q <= victim;
                end
            end else if (bus.n == CMD_INVAL) begin
                if (hit_any) valid_q[idx*WAYS + int'(hit_way)] <= 1'b0;
            end else if (bus.n == CMD_CLEAR) begin
                valid_q <= '0;
                lru_q   <= {SETS{LRU_INIT}};
            end
        end
    end

    // Tags need no reset: a stale tag is harmless while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (is_access && !hit_any) begin
            tag_q[idx][victim] <= tag;
        end
    end

    // Fill lands one edge after the miss; a later miss to the same way simply overwrites it.
    always_ff @(posedge clk) begin
        if (fill_pend_q) begin
            line_mem[{fill_set_q, fill_way_q}] <= bus.d_in;
        end
        line_rd_q <= line_mem[{idx, hit_way}];
    end

    // The read port exists for a future load-data path; nothing consumes it yet.
    assign unused_line_rd = ^line_rd_q;

    assign bus.hit     = hit_q;
    assign bus.miss    = miss_q;
    assign bus.add_out = add_out_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic compared
// against a queue-based LRU reference model.
module tb_data_cache;
    import cache_pkg::*;

    logic clk;
    logic rst_n;

    data_cache_if #(.LINE_BITS(512)) bus ();

    data_cache #(.SETS(256), .WAYS(4), .LINE_BITS(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: per-set valid/tag and a recency list (front = most recent).
    bit          mv [256][4];
    int unsigned mt [256][4];
    int          lru_order [256][$];
    logic [31:0] exp_add_out;

    task automatic model_clear();
        for (int s = 0; s < 256; s++) begin
            lru_order[s].delete();
            for (int i = 0; i < 4; i++) begin
                mv[s][i] = 1'b0;
                lru_order[s].push_back(i);
            end
        end
    endtask

    task automatic model_reset();
        model_clear();
        exp_add_out = 32'h0;
    endtask

    task automatic touch(input int s, input int w);
        int pos;
        pos = -1;
        for (int i = 0; i < lru_order[s].size(); i++) begin
            if (lru_order[s][i] == w) pos = i;
        end
        if (pos >= 0) lru_order[s].delete(pos);
        lru_order[s].push_front(w);
    endtask

    task automatic model_step(input logic [3:0] cmd, input logic [31:0] addr,
                              output bit eh, output bit em);
        int s, w, v;
        int unsigned t;
        s  = int'((addr >> 6) & 32'hFF);
        t  = addr >> 14;
        eh = 1'b0;
        em = 1'b0;
        w  = -1;
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && mv[s][i] && mt[s][i] == t) w = i;
        end
        case (cmd)
            4'h0, 4'h1: begin
                if (w >= 0) begin
                    eh = 1'b1;
                end else begin
                    em = 1'b1;
                    exp_add_out = addr & 32'hFFFF_FFC0;
                    v = -1;
                    for (int i = 0; i < 4; i++) begin
                        if (v < 0 && !mv[s][i]) v = i;
                    end
                    if (v < 0) v = lru_order[s][$];
                    mv[s][v] = 1'b1;
                    mt[s][v] = t;
                    w = v;
                end
                touch(s, w);
            end
            4'h3: if (w >= 0) mv[s][w] = 1'b0;
            4'h8: model_clear();
            default: ;
        endcase
    endtask

    // Drive one command at a falling edge and check the result one cycle later.
    // lit: 0 = model only, 1 = must hit, 2 = must miss, 3 = must give no pulse.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] addr, input int lit);
        bit eh, em;
        logic [1:0] want;
        bus.n      = cmd;
        bus.add_in = addr;
        for (int i = 0; i < 16; i++) bus.d_in[i*32 +: 32] = $urandom;
        @(negedge clk);
        model_step(cmd, addr, eh, em);
        txn++;
        $display("txn %0d n=%h add_in=%h -> hit=%b miss=%b add_out=%h",
                 txn, cmd, addr, bus.hit, bus.miss, bus.add_out);
        total++;
        if (bus.hit !== eh) begin
            bad++;
            $display("FAIL hit txn %0d addr=%h got=%b want=%b", txn, addr, bus.hit, eh);
        end
        total++;
        if (bus.miss !== em) begin
            bad++;
            $display("FAIL miss txn %0d addr=%h got=%b want=%b", txn, addr, bus.miss, em);
        end
        total++;
        if (bus.add_out !== exp_add_out) begin
            bad++;
            $display("FAIL add_out txn %0d got=%h want=%h", txn, bus.add_out, exp_add_out);
        end
        if (lit != 0) begin
            want = (lit == 1) ? 2'b10 : (lit == 2) ? 2'b01 : 2'b00;
            total++;
            if ({bus.hit, bus.miss} !== want) begin
                bad++;
                $display("FAIL directed txn %0d addr=%h got hit/miss=%b want=%b",
                         txn, addr, {bus.hit, bus.miss}, want);
            end
        end
        bus.n = 4'hF;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.n      = 4'hF;
        bus.add_in = '0;
        bus.d_in   = '0;
        model_reset();
        @(negedge clk);
        total++;
        if (bus.hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", bus.hit); end
        total++;
        if (bus.miss !== 1'b0) begin bad++; $display("FAIL reset_miss got=%b want=0", bus.miss); end
        total++;
        if (bus.add_out !== 32'h0) begin bad++; $display("FAIL reset_add_out got=%h want=0", bus.add_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(CMD_READ, 32'h0000_1000, 2);
        total++;
        if (bus.add_out !== 32'h0000_1000) begin
            bad++; $display("FAIL basic_add_out got=%h want=00001000", bus.add_out);
        end
        issue(CMD_READ, 32'h0000_1004, 1);
        total++;
        if (bus.add_out !== 32'h0000_1000) begin
            bad++; $display("FAIL basic_add_hold got=%h want=00001000", bus.add_out);
        end
    endtask

    task automatic test_eviction();
        issue(CMD_CLEAR, 32'h0, 3);
        for (int k = 0; k < 4; k++) issue(CMD_READ, 32'h0000_1000 + k * 32'h4000, 2);
        issue(CMD_READ, 32'h0000_1000, 1);
        issue(CMD_READ, 32'h0001_1000, 2);
        issue(CMD_READ, 32'h0000_9000, 1);
        issue(CMD_READ, 32'h0000_5000, 2);
    endtask

    task automatic test_write_allocate();
        issue(CMD_WRITE, 32'h0000_2000, 2);
        issue(CMD_READ,  32'h0000_2010, 1);
    endtask

    task automatic test_invalidate();
        issue(CMD_READ,  32'h0000_3000, 2);
        issue(CMD_INVAL, 32'h0000_3000, 3);
        issue(CMD_READ,  32'h0000_3000, 2);
        issue(CMD_READ,  32'h0000_3020, 1);
    endtask

    task automatic test_clear_and_noops();
        issue(CMD_READ,  32'h0000_4040, 0);
        issue(CMD_WRITE, 32'h0000_8080, 0);
        issue(CMD_READ,  32'h0000_4040, 1);
        issue(CMD_CLEAR, 32'h0000_4040, 3);
        issue(CMD_READ,  32'h0000_4040, 2);
        issue(CMD_IFETCH, 32'h0000_4040, 3);
        issue(CMD_PRINT,  32'h0000_8080, 3);
        issue(4'hF,       32'h0000_4040, 3);
        issue(CMD_READ,  32'h0000_4040, 1);
    endtask

    task automatic test_random();
        logic [3:0]  cmd;
        logic [31:0] addr;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 45) cmd = CMD_READ;
            else if (r < 80) cmd = CMD_WRITE;
            else if (r < 92) cmd = CMD_INVAL;
            else if (r < 95) cmd = CMD_IFETCH;
            else if (r < 97) cmd = CMD_PRINT;
            else if (r < 99) cmd = 4'hF;
            else             cmd = CMD_CLEAR;
            addr = (32'($urandom_range(0, 5)) << 14) | (32'($urandom_range(0, 3)) << 6)
                 | 32'($urandom_range(0, 63));
            issue(cmd, addr, 0);
        end
    endtask

    task automatic test_async_reset();
        bit eh, em;
        issue(CMD_READ, 32'h0000_1000, 0);
        bus.n      = CMD_READ;
        bus.add_in = 32'h0007_7000;
        @(posedge clk);
        #2;
        model_step(CMD_READ, 32'h0007_7000, eh, em);
        total++;
        if (bus.miss !== 1'b1 || em !== 1'b1) begin
            bad++; $display("FAIL pre_reset_miss got=%b want=1", bus.miss);
        end
        rst_n = 1'b0;
        bus.n = 4'hF;
        #1;
        model_reset();
        total++;
        if (bus.hit !== 1'b0) begin bad++; $display("FAIL async_hit got=%b want=0", bus.hit); end
        total++;
        if (bus.miss !== 1'b0) begin bad++; $display("FAIL async_miss got=%b want=0", bus.miss); end
        total++;
        if (bus.add_out !== 32'h0) begin bad++; $display("FAIL async_add_out got=%h want=0", bus.add_out); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(CMD_READ, 32'h0000_1000, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_eviction();
        test_write_allocate();
        test_invalidate();
        test_clear_and_noops();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
